// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer
//
// Takes a packed BCD word and streams it out as ASCII characters, most
// significant digit first. Leading zeros can be replaced by PAD_CHAR. A word
// containing any nibble above 9 is dropped. Each drop raises a one-cycle err
// pulse and bumps a saturating counter.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A source that raises valid keeps its data
// stable until that transfer. On the output side, out_valid is never
// withdrawn before the transfer.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input word handshake (in_ready high only in IDLE)
//   bcd_in               DIGITS packed BCD digits, digit 0 in bits [3:0]
//   blank_en             leading-zero blanking, captured with the word
//   out_valid/out_ready  output character handshake
//   out_data             ASCII character (8'h00 when idle)
//   out_last             marks the character of digit 0
//   err                  one-cycle pulse per rejected word
//   err_count            saturating count of rejected words
//   busy                 high in SEND (state visibility for checkers)
module bcd_ascii_streamer #(
    parameter int          DIGITS    = 4,
    parameter logic [7:0]  PAD_CHAR  = 8'h20,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*DIGITS-1:0]    bcd_in,
    input  logic                   blank_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   err,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [4*DIGITS-1:0]    word_q, word_d;
    logic                   blank_q, blank_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic                   bad_word;
    logic [3:0]             digit;
    logic                   hi_zero;
    logic [7:0]             char;

    // Any nibble above 9 makes the whole incoming word invalid.
    always_comb begin
        bad_word = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (bcd_in[j*4 +: 4] > 4'd9) begin
                bad_word = 1'b1;
            end
        end
    end

    // Select the current digit. hi_zero is set when this digit and every
    // digit above it are zero, meaning it is still a leading zero.
    always_comb begin
        digit   = 4'd0;
        hi_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (idx_q == IDX_W'(j)) begin
                digit = word_q[j*4 +: 4];
            end
            if ((IDX_W'(j) >= idx_q) && (word_q[j*4 +: 4] != 4'd0)) begin
                hi_zero = 1'b0;
            end
        end
    end

    // Digit 0 is never blanked, so an all-zero word still prints one '0'.
    always_comb begin
        if (blank_q && hi_zero && (idx_q != '0)) begin
            char = PAD_CHAR;
        end else begin
            char = 8'h30 + {4'h0, digit};
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        blank_d     = blank_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone means accept.
                if (in_valid) begin
                    if (bad_word) begin
                        err_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end else begin
                        word_d  = bcd_in;
                        blank_d = blank_en;
                        idx_d   = IDX_TOP;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            blank_q     <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            blank_q     <= blank_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    assign out_data  = busy ? char : 8'h00;
    assign out_last  = busy && (idx_q == '0);
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
module tb_bcd_ascii_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance, 2-bit error counter
  logic        in_valid, in_ready, blank_en, out_valid, out_ready, out_last, err, busy;
  logic [15:0] bcd_in;
  logic [7:0]  out_data;
  logic [1:0]  err_count;

  // 1-digit instance
  logic        in_valid1, in_ready1, blank1, out_valid1, out_ready1, out_last1, err1, busy1;
  logic [3:0]  bcd1;
  logic [7:0]  out_data1;
  logic [7:0]  err_count1;

  bcd_ascii_streamer #(.DIGITS(4), .PAD_CHAR(8'h20), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in), .blank_en(blank_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .err_count(err_count), .busy(busy)
  );

  bcd_ascii_streamer #(.DIGITS(1), .PAD_CHAR(8'h20), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .bcd_in(bcd1), .blank_en(blank1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
    .err(err1), .err_count(err_count1), .busy(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];   // {last, char}
  int   err_model = 0;
  logic stall_mode = 1'b0;
  int   stall_cnt = 0;
  int   cyc = 0;
  int   prev_xfer_cyc = 0;
  logic prev_last = 1'b1;
  logic check_ready_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_ready_next) begin
      check_eq("ready_after_last", in_ready, 1);
      check_eq("valid_after_last", out_valid, 0);
      check_ready_next = 1'b0;
    end
    if (!stall_mode) begin
      out_ready = 1'b1;
    end else if (out_valid && stall_cnt < 3) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else begin
      out_ready = 1'b1;
      if (out_valid) stall_cnt = 0;
    end
    if (out_valid) begin
      check_eq("in_ready_while_busy", in_ready, 0);
      check_eq("busy_flag", busy, 1);
      if (exp_q.size() == 0) begin
        check_eq("spurious_byte", out_valid, 0);
      end else begin
        check_eq("byte", {out_last, out_data}, exp_q[0]);
        if (out_ready) begin
          if (!stall_mode && !prev_last) check_eq("byte_gap", cyc - prev_xfer_cyc, 1);
          prev_xfer_cyc = cyc;
          prev_last = out_last;
          void'(exp_q.pop_front());
          if (out_last) check_ready_next = 1'b1;
        end
      end
    end else begin
      check_eq("busy_idle", busy, 0);
    end
  end

  function automatic logic word_ok(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = w[i*4 +: 4];
      if (d > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send_word(input logic [15:0] w, input logic b);
    logic good;
    logic seen;
    logic [8:0] item;
    int n;
    good = word_ok(w);
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    bcd_in   = w;
    blank_en = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", in_ready, 1);
    if (good) begin
      seen = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        logic [3:0] d;
        d = w[i*4 +: 4];
        if (d != 4'd0) seen = 1'b1;
        item[8] = (i == 0);
        if (b && !seen && i != 0) item[7:0] = 8'h20;
        else item[7:0] = 8'h30 + {4'h0, d};
        exp_q.push_back(item);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in   = 16'($urandom);   // must not disturb the word being sent
    blank_en = 1'($urandom);
    if (good) begin
      check_eq("first_byte_latency", out_valid, 1);
      check_eq("no_err_on_good", err, 0);
    end else begin
      if (err_model < 3) err_model++;
      check_eq("err_pulse", err, 1);
      check_eq("no_out_on_bad", out_valid, 0);
      check_eq("err_count", err_count, err_model);
      @(posedge clk);
      #1;
      check_eq("err_one_cycle", err, 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 0; bcd_in = '0; blank_en = 0; out_ready = 1;
    in_valid1 = 0; bcd1 = '0; blank1 = 0; out_ready1 = 1;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst1_in_ready", in_ready1, 1);
    check_eq("rst1_out_valid", out_valid1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_word(16'h1907, 1'b0); wait_idle();
    send_word(16'h0042, 1'b1); wait_idle();
    send_word(16'h0000, 1'b1); wait_idle();

    send_word(16'h12A4, 1'b0);
    send_word(16'hF000, 1'b0);
    send_word(16'h000B, 1'b1);
    send_word(16'h9C99, 1'b0);
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0D00, 1'b1);
    wait_idle();

    stall_mode = 1'b1;
    send_word(16'h5678, 1'b0); wait_idle();
    stall_mode = 1'b0;
    stall_cnt  = 0;

    // Reset in the middle of a word
    send_word(16'h9999, 1'b0);
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_out_last", out_last, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_err_count", err_count, 0);
    check_eq("mid_rst_busy", busy, 0);
    exp_q.delete();
    prev_last = 1'b1;
    check_ready_next = 1'b0;
    err_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(16'h0001, 1'b0); wait_idle();

    // Random words, back-to-back, with occasional bad nibbles and stalls
    for (int k = 0; k < 30; k++) begin
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) w[i*4 +: 4] = 4'($urandom_range(10, 15));
        else if ($urandom_range(0, 2) == 0) w[i*4 +: 4] = 4'd0;
        else w[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if (k % 10 == 0) begin
        wait_idle();
        stall_mode = 1'($urandom_range(0, 1));
        stall_cnt  = 0;
      end
      send_word(w, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    stall_mode = 1'b0;

    // One-digit instance
    @(negedge clk);
    in_valid1 = 1; bcd1 = 4'h9; blank1 = 0;
    @(posedge clk); #1;
    in_valid1 = 0;
    check_eq("d1_valid", out_valid1, 1);
    check_eq("d1_data_9", out_data1, 8'h39);
    check_eq("d1_last", out_last1, 1);
    check_eq("d1_not_ready", in_ready1, 0);
    @(posedge clk); #1;
    check_eq("d1_done_valid", out_valid1, 0);
    check_eq("d1_done_ready", in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1; bcd1 = 4'h0; blank1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    check_eq("d1_data_0_blank", out_data1, 8'h30);
    check_eq("d1_last_0", out_last1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid1 = 1; bcd1 = 4'hF; blank1 = 0;
    @(posedge clk); #1;
    in_valid1 = 0;
    check_eq("d1_err", err1, 1);
    check_eq("d1_no_out", out_valid1, 0);
    check_eq("d1_err_count", err_count1, 1);
    @(posedge clk); #1;
    check_eq("d1_err_one_cycle", err1, 0);
    check_eq("d1_still_idle", out_valid1, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
